// File: rtl/nano_viewer_pkg.sv
// Shared constants and state encoding for the UART picture loader.
package nano_viewer_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    localparam logic [1:0] ERR_SLOT = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    typedef enum logic [2:0] {IDLE, SLOT, PAYLOAD, CSUM, DRAIN} ldr_state_t;

endpackage

// File: rtl/pic_wr_fifo.sv
// Two-entry synchronous FIFO; the head entry drives dout straight from storage.
module pic_wr_fifo #(
    parameter int W = 54
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt;
    logic              do_push, do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pic_frame_loader.sv
// Framed UART picture loader: header, slot, payload packed into words, checksum;
// words leave through a 2-deep FIFO towards the PSRAM write port.
module pic_frame_loader
    import nano_viewer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 22,
    parameter int SLOTS      = 4,
    parameter int SLOT_WORDS = 1024,
    parameter int TIMEOUT    = 100000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(SLOTS)-1:0]   last_slot
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BC_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W  = (SLOT_WORDS > 1) ? $clog2(SLOT_WORDS) : 1;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    ldr_state_t         state, state_nx;
    logic [SLOT_W-1:0]  slot_q;
    logic [IDX_W-1:0]   word_idx;
    logic [BC_W-1:0]    byte_cnt;
    logic [7:0]         csum;
    logic [DATA_W-1:0]  pack, pack_nx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               good;

    logic               push, pop, abort, frame_ok, in_frame, tmo_hit, drain_done;
    logic [1:0]         abort_code;
    logic               byte_last, word_last;
    logic               fifo_full, fifo_empty;
    logic [ADDR_W-1:0]  push_addr;

    assign byte_last = (byte_cnt == BC_W'(BYTES - 1));
    assign word_last = (word_idx == IDX_W'(SLOT_WORDS - 1));
    assign push_addr = ADDR_W'(slot_q) * ADDR_W'(SLOT_WORDS) + ADDR_W'(word_idx);
    assign wr_valid  = !fifo_empty;
    assign pop       = wr_valid && wr_ready;
    assign busy      = (state != IDLE);
    assign in_frame  = (state == SLOT) || (state == PAYLOAD) || (state == CSUM);
    assign tmo_hit   = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    // FIFO is empty after this edge: already empty, or its last entry leaves now.
    assign drain_done = fifo_empty || (pop && !fifo_full);

    always_comb begin
        pack_nx = pack;
        for (int i = 0; i < BYTES; i++)
            if (byte_cnt == BC_W'(i)) pack_nx[i*8 +: 8] = rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        push       = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_SLOT;
        frame_ok   = 1'b0;
        case (state)
            IDLE:    if (rx_valid && rx_data == FRAME_HDR) state_nx = SLOT;
            SLOT:    if (rx_valid) begin
                         if (32'(rx_data) < SLOTS) state_nx = PAYLOAD;
                         else begin abort = 1'b1; abort_code = ERR_SLOT; end
                     end
            PAYLOAD: if (rx_valid && byte_last) begin
                         if (fifo_full && !pop) begin
                             abort = 1'b1; abort_code = ERR_OVF;
                         end else begin
                             push = 1'b1;
                             if (word_last) state_nx = CSUM;
                         end
                     end
            CSUM:    if (rx_valid) begin
                         if (rx_data != csum) begin
                             abort = 1'b1; abort_code = ERR_CSUM;
                         end else if (drain_done) begin
                             frame_ok = 1'b1; state_nx = IDLE;
                         end else state_nx = DRAIN;
                     end
            DRAIN:   if (drain_done) begin
                         frame_ok = good; state_nx = IDLE;
                     end
            default: state_nx = IDLE;
        endcase
        if (tmo_hit) begin
            abort = 1'b1; abort_code = ERR_TMO;
        end
        if (abort) state_nx = DRAIN;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slot_q    <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            pack      <= '0;
            tmo_cnt   <= '0;
            good      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            last_slot <= '0;
        end else begin
            done    <= frame_ok;
            err     <= abort;
            tmo_cnt <= (rx_valid || !in_frame) ? '0 : tmo_cnt + 1'b1;
            if (abort)    err_code  <= abort_code;
            if (frame_ok) last_slot <= slot_q;
            if (state == SLOT && rx_valid && !abort) begin
                slot_q   <= rx_data[SLOT_W-1:0];
                word_idx <= '0;
                byte_cnt <= '0;
                csum     <= '0;
                good     <= 1'b0;
            end
            if (state == PAYLOAD && rx_valid) begin
                csum     <= csum + rx_data;
                pack     <= pack_nx;
                byte_cnt <= byte_last ? '0 : byte_cnt + 1'b1;
                if (push) word_idx <= word_idx + 1'b1;
            end
            if (state == CSUM && rx_valid) good <= !abort;
            // An aborted frame drops whatever partial word was being packed.
            if (abort) begin
                byte_cnt <= '0;
                good     <= 1'b0;
            end
        end
    end

    pic_wr_fifo #(.W(ADDR_W + DATA_W)) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .din   ({push_addr, pack_nx}),
        .pop   (pop),
        .dout  ({wr_addr, wr_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
